// File: rtl/el2_exu_flush_ghr_ctl_if.sv
// ======================================================================
// el2_exu_flush_ghr_ctl_if: X/R-stage flush inputs and IFU flush/GHR outputs
// Rev 1.0
// ======================================================================
`default_nettype none

interface el2_exu_flush_ghr_ctl_if #(
  parameter int GHR_SIZE = 8,
  parameter int CNT_W    = 16
);
  logic                x_valid;
  logic                x_cond_br;
  logic                x_actual_taken;
  logic                x_flush_upper;
  logic [31:1]         x_flush_path;
  logic                r_flush_lower;
  logic [31:1]         r_flush_path;
  logic                cnt_clear;
  logic                ifu_flush_valid;
  logic [31:1]         ifu_flush_path;
  logic                x_kill;
  logic [GHR_SIZE-1:0] ghr_x;
  logic [GHR_SIZE-1:0] ghr_r;
  logic [CNT_W-1:0]    br_count;
  logic [CNT_W-1:0]    mispred_count;

  modport master (
    output x_valid, x_cond_br, x_actual_taken, x_flush_upper, x_flush_path,
           r_flush_lower, r_flush_path, cnt_clear,
    input  ifu_flush_valid, ifu_flush_path, x_kill, ghr_x, ghr_r,
           br_count, mispred_count
  );

  modport slave (
    input  x_valid, x_cond_br, x_actual_taken, x_flush_upper, x_flush_path,
           r_flush_lower, r_flush_path, cnt_clear,
    output ifu_flush_valid, ifu_flush_path, x_kill, ghr_x, ghr_r,
           br_count, mispred_count
  );
endinterface

`default_nettype wire

// File: rtl/el2_exu_flush_ghr_ctl.sv
// ======================================================================
// el2_exu_flush_ghr_ctl: IFU flush request, speculative/committed GHR, branch counters
// Rev 1.0
// ======================================================================
`default_nettype none

module el2_exu_flush_ghr_ctl #(
  parameter int GHR_SIZE = 8,
  parameter int CNT_W    = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_l,
  el2_exu_flush_ghr_ctl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                flush_valid;
  logic [31:1]         flush_path;
  logic                x_kill;
  logic [GHR_SIZE-1:0] ghr_x;
  logic [GHR_SIZE-1:0] ghr_r;
  logic [CNT_W-1:0]    br_count;
  logic [CNT_W-1:0]    mispred_count;

  // R-stage copy of the X branch; r_tk supplies the LSB of the committed history
  logic                r_v;
  logic                r_tk;
  logic                r_misp;
  logic [GHR_SIZE-2:0] r_ghr_hi;

  logic                xv;
  logic                x_upper;
  logic                flush_req;
  logic                commit;
  logic [GHR_SIZE-1:0] ghr_r_nxt;
  logic [GHR_SIZE-1:0] ghr_x_nxt;

  assign xv        = bus.x_valid & ~x_kill;
  assign x_upper   = xv & bus.x_flush_upper;
  assign flush_req = bus.r_flush_lower | x_upper;
  assign commit    = r_v & ~bus.r_flush_lower;
  assign ghr_r_nxt = commit ? {r_ghr_hi, r_tk} : ghr_r;

  always_comb begin
    ghr_x_nxt = ghr_x;
    if (bus.r_flush_lower) begin
      ghr_x_nxt = ghr_r_nxt;
    end else if (xv && bus.x_cond_br) begin
      ghr_x_nxt = {ghr_x[GHR_SIZE-2:0], bus.x_actual_taken};
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      flush_valid <= 1'b0;
      flush_path  <= '0;
      x_kill      <= 1'b0;
      ghr_x       <= '0;
      ghr_r       <= '0;
      r_v         <= 1'b0;
      r_tk        <= 1'b0;
      r_misp      <= 1'b0;
      r_ghr_hi    <= '0;
    end else begin
      flush_valid <= flush_req;
      if (bus.r_flush_lower) begin
        flush_path <= bus.r_flush_path;
      end else if (x_upper) begin
        flush_path <= bus.x_flush_path;
      end
      x_kill   <= flush_req;
      ghr_x    <= ghr_x_nxt;
      ghr_r    <= ghr_r_nxt;
      r_v      <= xv & bus.x_cond_br & ~bus.r_flush_lower;
      r_tk     <= bus.x_actual_taken;
      r_misp   <= bus.x_flush_upper;
      r_ghr_hi <= ghr_x_nxt[GHR_SIZE-1:1];
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (bus.cnt_clear) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (commit) begin
      if (br_count != CNT_MAX) begin
        br_count <= br_count + CNT_ONE;
      end
      if (r_misp && (mispred_count != CNT_MAX)) begin
        mispred_count <= mispred_count + CNT_ONE;
      end
    end
  end

  assign bus.ifu_flush_valid = flush_valid;
  assign bus.ifu_flush_path  = flush_path;
  assign bus.x_kill          = x_kill;
  assign bus.ghr_x           = ghr_x;
  assign bus.ghr_r           = ghr_r;
  assign bus.br_count        = br_count;
  assign bus.mispred_count   = mispred_count;

endmodule

`default_nettype wire

// File: tb/tb_el2_exu_flush_ghr_ctl.sv
// ======================================================================
// tb_el2_exu_flush_ghr_ctl: directed stimulus, flush-path scoreboard and state checks
// Rev 1.0
// ======================================================================
`default_nettype none

module tb_el2_exu_flush_ghr_ctl;

  localparam int GHR_SIZE = 8;
  localparam int CNT_W    = 4;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [31:1] exp_q[$];

  el2_exu_flush_ghr_ctl_if #(.GHR_SIZE(GHR_SIZE), .CNT_W(CNT_W)) bus ();

  el2_exu_flush_ghr_ctl #(.GHR_SIZE(GHR_SIZE), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.x_valid        = 1'b0;
    bus.x_cond_br      = 1'b0;
    bus.x_actual_taken = 1'b0;
    bus.x_flush_upper  = 1'b0;
    bus.x_flush_path   = '0;
    bus.r_flush_lower  = 1'b0;
    bus.r_flush_path   = '0;
    bus.cnt_clear      = 1'b0;
  endtask

  task automatic xbranch(input logic taken, input logic upper, input logic [31:1] path);
    idle();
    bus.x_valid        = 1'b1;
    bus.x_cond_br      = 1'b1;
    bus.x_actual_taken = taken;
    bus.x_flush_upper  = upper;
    bus.x_flush_path   = path;
  endtask

  // Every flush pulse the DUT presents must match the oldest expected path
  always @(negedge clk) begin
    if (rst_l === 1'b1 && bus.ifu_flush_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_flush actual_path=0x%08h", {bus.ifu_flush_path, 1'b0});
      end else begin
        logic [31:1] e;
        e = exp_q.pop_front();
        if (bus.ifu_flush_path !== e) begin
          failures++;
          $display("FAIL flush_path actual=0x%08h expected=0x%08h",
                   {bus.ifu_flush_path, 1'b0}, {e, 1'b0});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    // Reset and idle
    repeat (3) cyc();
    rst_l = 1'b1;
    repeat (5) cyc();
    chk("rst_flush_valid", 32'(bus.ifu_flush_valid), 0);
    chk("rst_flush_path", 32'(bus.ifu_flush_path), 0);
    chk("rst_x_kill", 32'(bus.x_kill), 0);
    chk("rst_ghr_x", 32'(bus.ghr_x), 0);
    chk("rst_ghr_r", 32'(bus.ghr_r), 0);
    chk("rst_br_count", 32'(bus.br_count), 0);
    chk("rst_mispred", 32'(bus.mispred_count), 0);

    // Taken then not-taken branches
    xbranch(1'b1, 1'b0, '0); cyc();
    chk("t2_ghr_x_1", 32'(bus.ghr_x), 32'h01);
    xbranch(1'b0, 1'b0, '0); cyc();
    chk("t2_ghr_x_2", 32'(bus.ghr_x), 32'h02);
    idle(); cyc(); cyc();
    chk("t2_ghr_r", 32'(bus.ghr_r), 32'h02);
    chk("t2_br_count", 32'(bus.br_count), 2);
    chk("t2_mispred", 32'(bus.mispred_count), 0);

    // Upper flush, then an ignored upper flush in the killed cycle
    xbranch(1'b1, 1'b1, 31'h2000_0080);
    exp_q.push_back(31'h2000_0080);
    cyc();
    chk("t3_flush_valid", 32'(bus.ifu_flush_valid), 1);
    chk("t3_x_kill", 32'(bus.x_kill), 1);
    chk("t3_ghr_x", 32'(bus.ghr_x), 32'h05);
    xbranch(1'b0, 1'b1, 31'h0000_1234); cyc();
    chk("t3_killed_no_pulse", 32'(bus.ifu_flush_valid), 0);
    chk("t3_kill_clear", 32'(bus.x_kill), 0);
    chk("t3_ghr_x_hold", 32'(bus.ghr_x), 32'h05);
    chk("t3_path_hold", 32'(bus.ifu_flush_path), 32'h2000_0080);
    chk("t3_ghr_r", 32'(bus.ghr_r), 32'h05);
    chk("t3_br_count", 32'(bus.br_count), 3);
    chk("t3_mispred", 32'(bus.mispred_count), 1);

    // Lower flush beats same-cycle upper flush and squashes pending R branch
    idle(); cyc();
    xbranch(1'b0, 1'b0, '0); cyc();
    chk("t4_ghr_x_spec", 32'(bus.ghr_x), 32'h0A);
    xbranch(1'b1, 1'b1, 31'h0000_0080);
    bus.r_flush_lower = 1'b1;
    bus.r_flush_path  = 31'h4000_0000;
    exp_q.push_back(31'h4000_0000);
    cyc();
    chk("t4_flush_path", 32'(bus.ifu_flush_path), 32'h4000_0000);
    chk("t4_ghr_x_restore", 32'(bus.ghr_x), 32'h05);
    chk("t4_ghr_r", 32'(bus.ghr_r), 32'h05);
    chk("t4_br_count", 32'(bus.br_count), 3);
    idle(); cyc();
    chk("t4_br_count_after", 32'(bus.br_count), 3);
    chk("t4_kill_clear", 32'(bus.x_kill), 0);

    // Counter saturation and clear priority
    bus.cnt_clear = 1'b1; cyc();
    chk("t5_clear_br", 32'(bus.br_count), 0);
    chk("t5_clear_misp", 32'(bus.mispred_count), 0);
    chk("t5_clear_ghr_r", 32'(bus.ghr_r), 32'h05);
    for (int i = 0; i < 14; i++) begin
      xbranch(1'b1, 1'b1, 31'h0000_0100);
      exp_q.push_back(31'h0000_0100);
      cyc();
      idle(); cyc();
    end
    chk("t5_pre_br", 32'(bus.br_count), 14);
    chk("t5_pre_misp", 32'(bus.mispred_count), 14);
    for (int i = 0; i < 3; i++) begin
      xbranch(1'b0, 1'b1, 31'h0000_0200);
      exp_q.push_back(31'h0000_0200);
      cyc();
      idle(); cyc();
    end
    chk("t5_sat_br", 32'(bus.br_count), 15);
    chk("t5_sat_misp", 32'(bus.mispred_count), 15);
    xbranch(1'b1, 1'b1, 31'h0000_0300);
    exp_q.push_back(31'h0000_0300);
    cyc();
    idle(); bus.cnt_clear = 1'b1; cyc();
    chk("t5_clear_wins_br", 32'(bus.br_count), 0);
    chk("t5_clear_wins_misp", 32'(bus.mispred_count), 0);
    idle(); cyc();

    // Reset during a flush pulse
    xbranch(1'b1, 1'b1, 31'h0000_0055); cyc();
    chk("t6_pulse_before_rst", 32'(bus.ifu_flush_valid), 1);
    rst_l = 1'b0;
    #1;
    chk("t6_flush_valid", 32'(bus.ifu_flush_valid), 0);
    chk("t6_flush_path", 32'(bus.ifu_flush_path), 0);
    chk("t6_x_kill", 32'(bus.x_kill), 0);
    chk("t6_ghr_x", 32'(bus.ghr_x), 0);
    chk("t6_ghr_r", 32'(bus.ghr_r), 0);
    chk("t6_br_count", 32'(bus.br_count), 0);
    idle();
    cyc(); cyc();
    rst_l = 1'b1;
    repeat (3) cyc();
    chk("t6_no_pulse_after", 32'(bus.ifu_flush_valid), 0);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
